cp0_intc: RTL and testbench
===========================

# cp0_intc

Parametrised coprocessor-0 with an integrated interrupt controller and count/compare timer; successor to the fixed 32-source-mask CP0. Holds STATUS, CAUSE, EPC, COUNT and COMPARE. Latches edge-triggered device interrupts into per-line pending bits and presents a masked, priority-encoded interrupt request to the pipeline controller. Supports nested exceptions via an EXL bit and exception return (`eret`). Sits beside the register file; the controller owns `mfc0`/`mtc0`, exception entry and `eret`.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: register width; must be ≥ 16.
- `ADDR_WIDTH`, default 32: PC/EPC width; must be ≤ `DATA_WIDTH`.
- `NUM_IRQ`, default 6: number of external interrupt lines, 1..7. The timer occupies line index `NUM_IRQ`.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `cp0_addr_r`, in, 5: read register number.
- `cp0_data_r`, out, `DATA_WIDTH`: read data, combinational.
- `cp0_we`, in, 1: `mtc0` write strobe.
- `cp0_addr_w`, in, 5: write register number.
- `cp0_data_w`, in, `DATA_WIDTH`: write data.
- `exception`, in, 1: exception/interrupt entry this cycle.
- `exc_code`, in, 5: cause code (0 = interrupt).
- `pc`, in, `ADDR_WIDTH`: PC of the faulting/interrupted instruction.
- `eret`, in, 1: exception return this cycle.
- `irq`, in, `NUM_IRQ`: device interrupt lines, level inputs, rising edge counts.
- `int_req`, out, 1: an interrupt should be taken.
- `int_id`, out, 3: index of the winning line.
- `epc_out`, out, `ADDR_WIDTH`: current EPC, used for the `eret` target.

## Operation
Register map (unlisted numbers read 0; writes to them are ignored):
- COUNT (9), read/write.
- COMPARE (11), read/write.
- STATUS (12):
  - bit 0: IE.
  - bit 1: EXL.
  - bits [8+NUM_IRQ:8]: IM.
  - All other bits read 0.
- CAUSE (13):
  - bits [6:2]: ExcCode, read-only via `mtc0`.
  - bits [8+NUM_IRQ:8]: IP, pending bits. Writing 1 clears a bit; writing 0 leaves it unchanged.
- EPC (14): zero-extended to `DATA_WIDTH`; writable.

Interrupt pending:
- External line i: the pending bit is set on a rising edge of `irq[i]`. The previous `irq` value is registered for edge detection.
- Timer line: COUNT increments every cycle and wraps modulo 2^`DATA_WIDTH`. The timer pending bit is set in the cycle COUNT's next value equals COMPARE. Any write to COMPARE clears the timer pending bit.
- A set and a clear in the same cycle: the set wins.

Interrupt request:
- `int_req` = IE & ~EXL & |(IP & IM).
- `int_id` = lowest index set in IP & IM (lowest index has highest priority); 0 when none.

Exception entry (`exception`=1):
- EXL←1.
- ExcCode←`exc_code`.
- EPC←`pc` only if EXL was 0. A nested exception keeps the original EPC.
- Pending bits are not cleared automatically; software clears them.

`eret`: EXL←0.

Precedence within one cycle:
- `exception` beats `eret`.
- `exception` beats an `mtc0` to STATUS, CAUSE or EPC (the write is dropped).
- An `mtc0` to COUNT replaces the increment.

## Timing
- Reads are combinational from current state. An `mtc0` is visible on `cp0_data_r` the cycle after `cp0_we`.
- `irq` rising edge at cycle n: IP set at edge n+1; `int_req` high during cycle n+1 if enabled.
- Exception at edge n: `int_req` low from cycle n+1 (EXL=1).
- Reset (`rst_n`=0 at an edge): all registers, IP and the registered previous-`irq` value become 0.
  - Outputs after reset: `cp0_data_r`=0 for all addresses, `int_req`=0, `int_id`=0, `epc_out`=0.
  - An `irq` line already high at reset deassertion produces no pending bit until it falls and rises again.
  - Reset overrides all simultaneous inputs.

## Structure
- Package `cp0_pkg`: register numbers (COUNT, COMPARE, STATUS, CAUSE, EPC), STATUS/CAUSE bit positions (IE, EXL, IM/IP base 8, ExcCode [6:2]) and ExcCode constants (INT=0, SYSCALL=8, RI=10).
- Sub-module `cp0_irq_pending`, parametrised by line count: edge detect, pending set/clear, masked priority encoder producing `any` and `id`.

## Test plan
- Reset: hold `rst_n`=0 with `irq`=all ones → after release every read = 0, `int_req`=0. Lines stay high → still no pending.
- Priority and masking:
  - STATUS←0x0301 (IE=1, IM bits 8,9 set); pulse `irq[1]` then `irq[0]` → `int_req`=1, `int_id`=0.
  - Write CAUSE←0x100 → `int_id`=1.
  - Write CAUSE←0x200 → `int_req`=0.
- Timer: COMPARE←20, COUNT←10 → timer IP set exactly 10 cycles later. `int_req` requires IM bit (8+NUM_IRQ). Write COMPARE → IP cleared.
- Nested exception: `exception`, `pc`=0x100, `exc_code`=8 → EPC=0x100, EXL=1. Second exception with `pc`=0x200, `exc_code`=10 → EPC stays 0x100, ExcCode=10. `eret` → EXL=0.
- Collisions in one cycle:
  - `exception`+`eret` → EXL=1.
  - `exception`+`mtc0` EPC←0x55 → EPC=`pc`.
  - `irq` rise + W1C of the same bit → bit remains set.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 block: register numbers, STATUS/CAUSE bit
// positions, ExcCode values and a small priority helper.
package cp0_pkg;

   // CP0 register numbers
   localparam logic [4:0] RegCount   = 5'd9;
   localparam logic [4:0] RegCompare = 5'd11;
   localparam logic [4:0] RegStatus  = 5'd12;
   localparam logic [4:0] RegCause   = 5'd13;
   localparam logic [4:0] RegEpc     = 5'd14;

   // STATUS / CAUSE bit positions
   localparam int unsigned StatusIe     = 0;
   localparam int unsigned StatusExl    = 1;
   localparam int unsigned IntBase      = 8;  // IM in STATUS, IP in CAUSE
   localparam int unsigned ExcCodeLsb   = 2;
   localparam int unsigned ExcCodeWidth = 5;

   // ExcCode values
   localparam logic [4:0] ExcInt     = 5'd0;
   localparam logic [4:0] ExcSyscall = 5'd8;
   localparam logic [4:0] ExcRi      = 5'd10;

   // Index of the lowest set bit, 0 when the vector is empty
   function automatic logic [2:0] lowest_set(input logic [7:0] vec);
      logic [2:0] idx;
      idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/cp0_irq_pending.sv
// Interrupt pending bits: edge detection on the external lines, a timer set
// input, write-one-to-clear, and a masked lowest-index-wins priority encoder.
module cp0_irq_pending
   import cp0_pkg::*;
#(
   parameter int unsigned NumExt = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NumExt-1:0] irq,
   input  logic            timer_set,
   input  logic [NumExt:0] clr,
   input  logic [NumExt:0] mask,
   output logic [NumExt:0] pending,
   output logic            any,
   output logic [2:0]      id
);

   logic [NumExt-1:0] irq_prev_q;
   logic              armed_q;
   logic [NumExt:0]   pend_q, pend_d;
   logic [NumExt:0]   set;
   logic [7:0]        masked;

   // Set beats clear. Edges are ignored in the first cycle after reset so a
   // line held high through reset is not mistaken for a fresh request.
   always_comb begin
      set               = '0;
      set[NumExt-1:0]   = armed_q ? (irq & ~irq_prev_q) : '0;
      set[NumExt]       = timer_set;
      pend_d            = set | (pend_q & ~clr);
   end

   // Pending bits, previous irq sample and the post-reset arm flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_prev_q <= '0;
         armed_q    <= 1'b0;
         pend_q     <= '0;
      end else begin
         irq_prev_q <= irq;
         armed_q    <= 1'b1;
         pend_q     <= pend_d;
      end
   end

   // Masked priority encode
   always_comb begin
      masked           = '0;
      masked[NumExt:0] = pend_q & mask;
      any              = |masked;
      id               = lowest_set(masked);
   end

   assign pending = pend_q;

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0 with integrated interrupt controller and count/compare timer.
// Holds STATUS, CAUSE, EPC, COUNT and COMPARE; the pipeline controller drives
// mtc0, exception entry and eret.
module cp0_intc
   import cp0_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_IRQ    = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4:0]            cp0_addr_r,
   output logic [DATA_WIDTH-1:0] cp0_data_r,
   input  logic                  cp0_we,
   input  logic [4:0]            cp0_addr_w,
   input  logic [DATA_WIDTH-1:0] cp0_data_w,
   input  logic                  exception,
   input  logic [4:0]            exc_code,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  eret,
   input  logic [NUM_IRQ-1:0]    irq,
   output logic                  int_req,
   output logic [2:0]            int_id,
   output logic [ADDR_WIDTH-1:0] epc_out
);

   localparam int unsigned NumLines = NUM_IRQ + 1;

   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] compare_q, compare_d;
   logic                  ie_q, ie_d;
   logic                  exl_q, exl_d;
   logic [NUM_IRQ:0]      im_q, im_d;
   logic [4:0]            exc_code_q, exc_code_d;
   logic [ADDR_WIDTH-1:0] epc_q, epc_d;

   logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic [NUM_IRQ:0] ip;
   logic [NUM_IRQ:0] ip_clr;
   logic             ip_any;
   logic [2:0]       ip_id;
   logic             timer_set;

   assign wr_count   = cp0_we && (cp0_addr_w == RegCount);
   assign wr_compare = cp0_we && (cp0_addr_w == RegCompare);
   assign wr_status  = cp0_we && (cp0_addr_w == RegStatus);
   assign wr_cause   = cp0_we && (cp0_addr_w == RegCause);
   assign wr_epc     = cp0_we && (cp0_addr_w == RegEpc);

   // Next state: exception entry overrides eret and mtc0 to STATUS/CAUSE/EPC
   always_comb begin
      count_d    = wr_count ? cp0_data_w : count_q + DATA_WIDTH'(1);
      compare_d  = wr_compare ? cp0_data_w : compare_q;
      ie_d       = ie_q;
      exl_d      = exl_q;
      im_d       = im_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      ip_clr     = '0;
      if (exception) begin
         exl_d      = 1'b1;
         exc_code_d = exc_code;
         // A nested exception keeps the original return address
         if (!exl_q) epc_d = pc;
      end else begin
         if (wr_status) begin
            ie_d  = cp0_data_w[StatusIe];
            exl_d = cp0_data_w[StatusExl];
            im_d  = cp0_data_w[IntBase +: NumLines];
         end
         if (eret) exl_d = 1'b0;
         if (wr_epc) epc_d = cp0_data_w[ADDR_WIDTH-1:0];
         if (wr_cause) ip_clr = cp0_data_w[IntBase +: NumLines];
      end
      if (wr_compare) ip_clr[NUM_IRQ] = 1'b1;
   end

   // Timer fires when the value COUNT is about to take matches COMPARE
   assign timer_set = (count_d == compare_q);

   // Architectural register state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q    <= '0;
         compare_q  <= '0;
         ie_q       <= 1'b0;
         exl_q      <= 1'b0;
         im_q       <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         count_q    <= count_d;
         compare_q  <= compare_d;
         ie_q       <= ie_d;
         exl_q      <= exl_d;
         im_q       <= im_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   cp0_irq_pending #(
      .NumExt (NUM_IRQ)
   ) u_pending (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq       (irq),
      .timer_set (timer_set),
      .clr       (ip_clr),
      .mask      (im_q),
      .pending   (ip),
      .any       (ip_any),
      .id        (ip_id)
   );

   // Combinational register read
   always_comb begin
      cp0_data_r = '0;
      case (cp0_addr_r)
         RegCount:   cp0_data_r = count_q;
         RegCompare: cp0_data_r = compare_q;
         RegStatus: begin
            cp0_data_r[StatusIe]             = ie_q;
            cp0_data_r[StatusExl]            = exl_q;
            cp0_data_r[IntBase +: NumLines]  = im_q;
         end
         RegCause: begin
            cp0_data_r[ExcCodeLsb +: ExcCodeWidth] = exc_code_q;
            cp0_data_r[IntBase +: NumLines]        = ip;
         end
         RegEpc:     cp0_data_r[ADDR_WIDTH-1:0] = epc_q;
         default:    cp0_data_r = '0;
      endcase
   end

   assign int_req = ie_q & ~exl_q & ip_any;
   assign int_id  = ip_id;
   assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the register file and interrupt rules.
module tb_cp0_intc;
   import cp0_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NI = 6;
   localparam int NL = NI + 1;

   logic          clk;
   logic          rst_n;
   logic [4:0]    cp0_addr_r;
   logic [DW-1:0] cp0_data_r;
   logic          cp0_we;
   logic [4:0]    cp0_addr_w;
   logic [DW-1:0] cp0_data_w;
   logic          exception;
   logic [4:0]    exc_code;
   logic [AW-1:0] pc;
   logic          eret;
   logic [NI-1:0] irq;
   logic          int_req;
   logic [2:0]    int_id;
   logic [AW-1:0] epc_out;

   cp0_intc #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_IRQ    (NI)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cp0_addr_r (cp0_addr_r),
      .cp0_data_r (cp0_data_r),
      .cp0_we     (cp0_we),
      .cp0_addr_w (cp0_addr_w),
      .cp0_data_w (cp0_data_w),
      .exception  (exception),
      .exc_code   (exc_code),
      .pc         (pc),
      .eret       (eret),
      .irq        (irq),
      .int_req    (int_req),
      .int_id     (int_id),
      .epc_out    (epc_out)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   logic [31:0] m_count, m_compare, m_epc;
   bit          m_ie, m_exl, m_armed;
   bit [NL-1:0] m_im, m_ip;
   bit [4:0]    m_exc;
   bit [NI-1:0] m_prev;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rd(input logic [4:0] a);
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return 32'(m_ie) + 32'(m_exl) * 2 + 32'(m_im) * 256;
         5'd13:   return 32'(m_exc) * 4 + 32'(m_ip) * 256;
         5'd14:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int model_id();
      for (int i = 0; i < NL; i++) if (m_ip[i] && m_im[i]) return i;
      return 0;
   endfunction

   function automatic bit model_req();
      return m_ie && !m_exl && ((m_ip & m_im) != 0);
   endfunction

   // Advance the model by one clock edge using the inputs applied this cycle
   task automatic model_step();
      logic [31:0] nc;
      bit          w1c, wcmp;
      if (!rst_n) begin
         m_count = 0; m_compare = 0; m_epc = 0; m_ie = 0; m_exl = 0;
         m_armed = 0; m_im = 0; m_ip = 0; m_exc = 0; m_prev = 0;
         return;
      end
      nc   = (cp0_we && cp0_addr_w == 5'd9) ? cp0_data_w : m_count + 1;
      w1c  = cp0_we && cp0_addr_w == 5'd13 && !exception;
      wcmp = cp0_we && cp0_addr_w == 5'd11;
      for (int i = 0; i < NI; i++)
         m_ip[i] = (m_armed && irq[i] && !m_prev[i]) || (m_ip[i] && !(w1c && cp0_data_w[8+i]));
      m_ip[NI] = (nc == m_compare) || (m_ip[NI] && !(w1c && cp0_data_w[8+NI]) && !wcmp);
      m_prev  = irq;
      m_armed = 1;
      m_count = nc;
      if (wcmp) m_compare = cp0_data_w;
      if (exception) begin
         if (!m_exl) m_epc = pc;
         m_exl = 1;
         m_exc = exc_code;
      end else begin
         if (cp0_we && cp0_addr_w == 5'd12) begin
            m_ie  = cp0_data_w[0];
            m_exl = cp0_data_w[1];
            m_im  = cp0_data_w[8 +: NL];
         end
         if (eret) m_exl = 0;
         if (cp0_we && cp0_addr_w == 5'd14) m_epc = cp0_data_w;
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("rd_data", cp0_data_r, model_rd(cp0_addr_r));
         check("int_req", 32'(int_req), 32'(model_req()));
         check("int_id", 32'(int_id), 32'(model_id()));
         check("epc_out", epc_out, m_epc);
      end
   end

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      cp0_we    = 1'b0;
      exception = 1'b0;
      eret      = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cp0_we     = 1'b1;
      cp0_addr_w = a;
      cp0_data_w = d;
      cycle();
   endtask

   task automatic expect_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
      cp0_addr_r = a;
      #1;
      check(name, cp0_data_r, exp);
   endtask

   initial begin
      logic [4:0] addrs [6];
      logic [4:0] reset_addrs [7];
      addrs       = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
      reset_addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};

      rst_n = 1'b0; cp0_addr_r = '0; cp0_we = 1'b0; cp0_addr_w = '0; cp0_data_w = '0;
      exception = 1'b0; exc_code = '0; pc = '0; eret = 1'b0; irq = '1;

      // Reset with every irq line held high
      cycle();
      chk_en = 1'b1;
      cycle();
      cycle();
      rst_n = 1'b1;
      check("rst_int_req", 32'(int_req), 32'd0);
      check("rst_int_id", 32'(int_id), 32'd0);
      check("rst_epc_out", epc_out, 32'd0);
      foreach (reset_addrs[k]) expect_rd("rst_read", reset_addrs[k], 32'd0);
      repeat (3) cycle();
      expect_rd("rst_no_pending", RegCause, 32'd0);
      irq = '0;
      cycle();

      // Priority and masking
      wr(RegStatus, 32'h0301);
      irq = 6'b000010; cycle();
      irq = 6'b000000; cycle();
      irq = 6'b000001; cycle();
      irq = 6'b000000; cycle();
      check("prio_req", 32'(int_req), 32'd1);
      check("prio_id0", 32'(int_id), 32'd0);
      wr(RegCause, 32'h100);
      check("prio_id1", 32'(int_id), 32'd1);
      wr(RegCause, 32'h200);
      check("mask_req_low", 32'(int_req), 32'd0);
      expect_rd("cause_clear", RegCause, 32'd0);

      // Timer
      wr(RegCompare, 32'd20);
      wr(RegCount, 32'd10);
      repeat (9) cycle();
      expect_rd("timer_early", RegCause, 32'd0);
      cycle();
      expect_rd("timer_fire", RegCause, 32'h4000);
      check("timer_masked", 32'(int_req), 32'd0);
      wr(RegStatus, 32'h4001);
      check("timer_req", 32'(int_req), 32'd1);
      check("timer_id", 32'(int_id), 32'd6);
      wr(RegCompare, 32'd1000);
      expect_rd("timer_clr", RegCause, 32'd0);
      check("timer_clr_req", 32'(int_req), 32'd0);

      // Nested exceptions
      exception = 1'b1; pc = 32'h100; exc_code = ExcSyscall;
      cycle();
      expect_rd("exc1_epc", RegEpc, 32'h100);
      expect_rd("exc1_status", RegStatus, 32'h4003);
      expect_rd("exc1_cause", RegCause, 32'h20);
      exception = 1'b1; pc = 32'h200; exc_code = ExcRi;
      cycle();
      check("exc2_epc_out", epc_out, 32'h100);
      expect_rd("exc2_cause", RegCause, 32'h28);
      eret = 1'b1;
      cycle();
      expect_rd("eret_status", RegStatus, 32'h4001);

      // Same-cycle collisions
      exception = 1'b1; eret = 1'b1; pc = 32'h180; exc_code = ExcInt;
      cycle();
      expect_rd("exc_eret_status", RegStatus, 32'h4003);
      eret = 1'b1; cycle();
      exception = 1'b1; pc = 32'h300; exc_code = ExcInt;
      cp0_we = 1'b1; cp0_addr_w = RegEpc; cp0_data_w = 32'h55;
      cycle();
      expect_rd("exc_mtc0_epc", RegEpc, 32'h300);
      eret = 1'b1; cycle();
      irq = 6'b000100;
      cp0_we = 1'b1; cp0_addr_w = RegCause; cp0_data_w = 32'h400;
      cycle();
      expect_rd("set_beats_clr", RegCause, 32'h400);
      irq = '0;
      wr(RegCause, 32'h400);

      // Randomized traffic checked against the model every cycle
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] wa;
         cp0_addr_r = addrs[$urandom_range(0, 5)];
         irq = irq ^ NI'($urandom & $urandom);
         if ($urandom_range(0, 3) == 0) begin
            wa = addrs[$urandom_range(0, 5)];
            cp0_we     = 1'b1;
            cp0_addr_w = wa;
            cp0_data_w = $urandom;
            if (wa == RegCompare && $urandom_range(0, 1) == 1)
               cp0_data_w = m_count + $urandom_range(2, 40);
            if (wa == RegCount && $urandom_range(0, 1) == 1)
               cp0_data_w = m_compare - $urandom_range(1, 30);
            if (wa == RegStatus && $urandom_range(0, 1) == 1)
               cp0_data_w = ($urandom | 32'h1) & ~32'h2;
         end
         exception = ($urandom_range(0, 15) == 0);
         pc        = $urandom;
         exc_code  = 5'($urandom);
         eret      = ($urandom_range(0, 7) == 0) && !(cp0_we && cp0_addr_w == RegStatus);
         cycle();
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
